// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver with mid-bit sampling.
// Framing errors hold off new frames until the line idles high.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int N = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] C_LAST = 16'(N - 1);
  localparam logic [15:0] C_HALF = 16'((N - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      r_state;
  logic        r_s1;
  logic        r_s2;
  logic [15:0] r_count;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;

  logic w_bit_end;
  logic w_half;

  assign w_bit_end = (r_count == C_LAST);
  assign w_half    = (r_count == C_HALF);
  assign rx_busy   = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_s1         <= 1'b1;
      r_s2         <= 1'b1;
      r_count      <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      r_s1         <= rx_line;
      r_s2         <= r_s1;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_count <= '0;
          r_idx   <= '0;
          if (!r_s2) r_state <= START;
        end
        START: begin
          if (w_half) begin
            r_count <= '0;
            // A line back high at mid-start is noise, not a frame
            r_state <= r_s2 ? IDLE : DATA;
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_count        <= '0;
            r_shift[r_idx] <= r_s2;
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_count <= '0;
            if (r_s2) begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
              r_state  <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              r_state      <= WAIT_HIGH;
            end
          end else begin
            r_count <= r_count + 16'd1;
          end
        end
        WAIT_HIGH: begin
          r_count <= '0;
          if (r_s2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized checks of uart_rx
// against a frame-level model (N=10, H=4).
module tb_uart_rx;

  localparam int N   = 10;
  localparam int H   = (N - 1) / 2;
  localparam int LAT = H + 9 * N + 4;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         hold;
    int         gap;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  act_q[$];
  ev_t  last_act[$];
  vec_t vecs[5];

  uart_rx #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_line     (rx_line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic chk_near(input string name, input int act,
                          input int exp);
    n_chk++;
    if (act < exp - 1 || act > exp + 1) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d+-1", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit err, input logic [7:0] d,
                          input int start);
    ev_t e;
    e.err  = err;
    e.data = d;
    e.cyc  = start + LAT;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int hold, input int gap,
                            input bit chk_busy);
    logic [9:0] bits;
    int nlow;
    bits = {stop, d, 1'b0};
    nlow = 0;
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (5) @(negedge clk);
      if (!rx_busy) nlow++;
      repeat (5) @(negedge clk);
    end
    if (hold > 0) begin
      rx_line = 1'b0;
      repeat (hold) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (gap) @(negedge clk);
    if (chk_busy) chk("busy during frame", nlow, 0);
  endtask

  task automatic drain(input string name);
    ev_t e;
    ev_t a;
    int  t;
    t = 0;
    while (act_q.size() < exp_q.size() && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk({name, " event count"}, act_q.size(), exp_q.size());
    last_act = act_q;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({name, " event kind"}, 32'(a.err), 32'(e.err));
      chk({name, " rx_data"}, 32'(a.data), 32'(e.data));
      chk_near({name, " event cycle"}, a.cyc, e.cyc);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    logic [7:0] model_last;
    int         s;
    int         seen;
    int         sp;
    logic [7:0] d;
    bit         stp;
    int         hold;
    int         gap;

    vecs[0] = '{8'hA5, 1'b1, 0, 20, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0, 20, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 30, 20, 1'b1, 8'hFF};
    vecs[4] = '{8'h3C, 1'b1, 0, 20, 1'b0, 8'h3C};

    rst_n   = 1'b0;
    rx_line = 1'b1;

    fork
      begin : monitor
        bit pv;
        bit pe;
        ev_t a;
        pv = 1'b0;
        pe = 1'b0;
        forever begin
          @(negedge clk);
          if (rx_valid || rx_frame_err) begin
            chk("single-cycle exclusive pulse",
                32'(!(rx_valid && rx_frame_err) &&
                    !(rx_valid && pv) && !(rx_frame_err && pe)), 1);
            a.err  = rx_frame_err;
            a.data = rx_data;
            a.cyc  = cyc;
            act_q.push_back(a);
          end
          pv = rx_valid;
          pe = rx_frame_err;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset rx_data", 32'(rx_data), 0);
    chk("reset rx_valid", 32'(rx_valid), 0);
    chk("reset rx_frame_err", 32'(rx_frame_err), 0);
    chk("reset rx_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].exp_err, vecs[i].exp_data, cyc);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold,
                 vecs[i].gap, 1'b1);
    end
    drain("table");
    sp = (last_act.size() >= 3) ? last_act[2].cyc - last_act[1].cyc : -1;
    chk_near("back-to-back spacing", sp, 10 * N);

    seen = 0;
    rx_line = 1'b0;
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1;
    end
    chk("glitch busy seen", 32'(seen), 1);
    chk("glitch busy cleared", 32'(rx_busy), 0);
    drain("glitch");

    fork
      send_frame(8'hF0, 1'b1, 0, 20, 1'b0);
      begin
        repeat (55) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset rx_data", 32'(rx_data), 0);
        chk("midreset rx_valid", 32'(rx_valid), 0);
        chk("midreset rx_frame_err", 32'(rx_frame_err), 0);
        chk("midreset rx_busy", 32'(rx_busy), 0);
      end
    join
    push_exp(1'b0, 8'h81, cyc);
    send_frame(8'h81, 1'b1, 0, 10, 1'b1);
    drain("after reset");
    model_last = 8'h81;

    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom_range(0, 255));
      stp  = ($urandom_range(0, 4) != 0);
      hold = stp ? 0 : int'($urandom_range(0, 20));
      gap  = stp ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      if (stp) begin
        push_exp(1'b0, d, cyc);
        model_last = d;
      end else begin
        push_exp(1'b1, model_last, cyc);
      end
      send_frame(d, stp, hold, gap, 1'b1);
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
